pixel_buffer_ctrl: RTL and testbench

PIXEL_BUFFER_CTRL -- requirements
Module: pixel_buffer_ctrl

---
 rtl/pixel_buffer_ctrl.sv | 137 +++++++++++++
 tb/tb_pixel_buffer_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_buffer_ctrl.sv
// pixel_buffer_ctrl
//   Ring-FIFO controller that streams pixels through a dual-port SRAM
//   (port A read, port B write) and delivers them on a registered
//   valid/ready output with a two-word output stage (out word + skid word).
//
// Ports
//   clk, rst_n            single clock, asynchronous active-low reset
//   flush                 synchronous clear of all buffer state
//   wr_valid/wr_ready/wr_data   producer side
//   rd_valid/rd_ready/rd_data   consumer side, rd_data registered
//   level                 words held (SRAM + in-flight read + output stage)
//   sram_oea/sram_a/sram_doa    SRAM port A (read, 1-cycle latency)
//   sram_webn/sram_b/sram_dib   SRAM port B (write, active-low lane enables)
//   sram_oeb              port B output enable, tied low
module pixel_buffer_ctrl #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [10:0]       level,
  output logic              sram_oea,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_doa,
  output logic [2:0]        sram_webn,
  output logic [ADDR_W-1:0] sram_b,
  output logic [DATA_W-1:0] sram_dib,
  output logic              sram_oeb
);

  localparam logic [ADDR_W:0]   FULL_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(DEPTH - 1);

  // Pointer advance with explicit wrap so non-power-of-two depths also work.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    ptr_inc = (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_count_q, mem_count_d;
  logic [1:0]        held_q, held_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic       wr_fire;
  logic       pop;
  logic       rd_issue;
  logic [2:0] stage_after;
  logic [1:0] kept;

  always_comb begin
    wr_ready = rst_n & ~flush & (mem_count_q != FULL_C);
    wr_fire  = wr_valid & wr_ready;
    rd_valid = (held_q != 2'd0);
    pop      = rd_valid & rd_ready;

    // Words the stage will hold next cycle if no new read is issued; a new
    // read is only launched when its data is guaranteed a free slot.
    stage_after = {1'b0, held_q} + {2'b00, pend_q} - {2'b00, pop};
    rd_issue    = ~flush & (mem_count_q != '0) & (stage_after < 3'd2);

    wr_ptr_d    = wr_fire  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = rd_issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    mem_count_d = mem_count_q + (ADDR_W+1)'(wr_fire) - (ADDR_W+1)'(rd_issue);
    pend_d      = rd_issue;

    // Output stage: pop shifts skid into out, then returning SRAM data
    // fills the first free slot so order is preserved.
    kept   = held_q - {1'b0, pop};
    out_d  = out_q;
    skid_d = skid_q;
    if (pop) begin
      out_d = skid_q;
    end
    if (pend_q) begin
      if (kept == 2'd0) begin
        out_d = sram_doa;
      end else begin
        skid_d = sram_doa;
      end
    end
    held_d = kept + {1'b0, pend_q};

    // Flush drops everything, including the read returning this cycle.
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
      pend_d      = 1'b0;
      held_d      = 2'd0;
    end

    sram_oea  = rd_issue;
    sram_a    = rd_issue ? rd_ptr_q : '0;
    sram_webn = wr_fire ? 3'b000 : 3'b111;
    sram_b    = wr_fire ? wr_ptr_q : '0;
    sram_dib  = wr_fire ? wr_data : '0;
    sram_oeb  = 1'b0;

    rd_data = out_q;
    level   = 11'(mem_count_q) + 11'(held_q) + 11'(pend_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      held_q      <= 2'd0;
      pend_q      <= 1'b0;
      out_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      held_q      <= held_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
    end
  end

  // Skid word is only ever read when held says it is valid.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pixel_buffer_ctrl.sv
module tb_pixel_buffer_ctrl;

  localparam int DATA_W = 48;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [10:0]       level;
  logic              sram_oea;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_doa;
  logic [2:0]        sram_webn;
  logic [ADDR_W-1:0] sram_b;
  logic [DATA_W-1:0] sram_dib;
  logic              sram_oeb;

  always #5 clk = ~clk;

  pixel_buffer_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level),
    .sram_oea(sram_oea), .sram_a(sram_a), .sram_doa(sram_doa),
    .sram_webn(sram_webn), .sram_b(sram_b), .sram_dib(sram_dib),
    .sram_oeb(sram_oeb)
  );

  // SRAM model: port A data valid only the cycle after the request.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_oea) sram_doa <= mem[sram_a];
    else          sram_doa <= 48'hDEAD_BEEF_DEAD;
    for (int l = 0; l < 3; l++) begin
      if (!sram_webn[l]) mem[sram_b][l*16 +: 16] <= sram_dib[l*16 +: 16];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted word must come out once, in order.
  logic [DATA_W-1:0] sb[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      chk("level_vs_model", 64'(level), 64'(sb.size()));
      if (flush) begin
        sb.delete();
      end else begin
        if (rd_valid && rd_ready) begin
          if (sb.size() == 0) chk("pop_on_empty", 64'(1), 64'(0));
          else chk("rd_data_order", 64'(rd_data), 64'(sb.pop_front()));
        end
        if (wr_valid && wr_ready) sb.push_back(wr_data);
      end
    end
  end

  typedef struct packed {
    logic        wv;
    logic [47:0] wd;
    logic        rr;
    logic        fl;
    logic [2:0]  webn;
    logic [9:0]  b;
    logic        oea;
    logic [9:0]  a;
    logic        rv;
    logic [47:0] rdat;
    logic [10:0] lvl;
    logic        wrdy;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] pat(input int i);
    logic [15:0] s;
    s = 16'(i);
    pat = {s ^ 16'h5A5A, s, ~s};
  endfunction

  task automatic drain(input int bound);
    int n;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'(0));
    tick();
    chk("drained_level", 64'(level), 64'(0));
    chk("drained_rd_valid", 64'(rd_valid), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n;

    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;

    //                wv  wd                 rr   fl    webn    b      oea   a      rv    rdat              lvl    wrdy
    tbl[0]  = '{1'b1, 48'h1234_5678_9ABC, 1'b1, 1'b0, 3'b000, 10'd0, 1'b0, 10'd0, 1'b0, 48'h0,            11'd0, 1'b1};
    tbl[1]  = '{1'b0, 48'h0,              1'b1, 1'b0, 3'b111, 10'd0, 1'b1, 10'd0, 1'b0, 48'h0,            11'd1, 1'b1};
    tbl[2]  = '{1'b0, 48'h0,              1'b1, 1'b0, 3'b111, 10'd0, 1'b0, 10'd0, 1'b0, 48'h0,            11'd1, 1'b1};
    tbl[3]  = '{1'b0, 48'h0,              1'b1, 1'b0, 3'b111, 10'd0, 1'b0, 10'd0, 1'b1, 48'h1234_5678_9ABC, 11'd1, 1'b1};
    tbl[4]  = '{1'b0, 48'h0,              1'b0, 1'b0, 3'b111, 10'd0, 1'b0, 10'd0, 1'b0, 48'h0,            11'd0, 1'b1};
    tbl[5]  = '{1'b1, 48'hA1A1_0000_0001, 1'b0, 1'b0, 3'b000, 10'd1, 1'b0, 10'd0, 1'b0, 48'h0,            11'd0, 1'b1};
    tbl[6]  = '{1'b1, 48'hA2A2_0000_0002, 1'b0, 1'b0, 3'b000, 10'd2, 1'b1, 10'd1, 1'b0, 48'h0,            11'd1, 1'b1};
    tbl[7]  = '{1'b0, 48'h0,              1'b0, 1'b0, 3'b111, 10'd0, 1'b1, 10'd2, 1'b0, 48'h0,            11'd2, 1'b1};
    tbl[8]  = '{1'b0, 48'h0,              1'b0, 1'b0, 3'b111, 10'd0, 1'b0, 10'd0, 1'b1, 48'hA1A1_0000_0001, 11'd2, 1'b1};
    tbl[9]  = '{1'b0, 48'h0,              1'b1, 1'b0, 3'b111, 10'd0, 1'b0, 10'd0, 1'b1, 48'hA1A1_0000_0001, 11'd2, 1'b1};
    tbl[10] = '{1'b0, 48'h0,              1'b1, 1'b0, 3'b111, 10'd0, 1'b0, 10'd0, 1'b1, 48'hA2A2_0000_0002, 11'd1, 1'b1};
    tbl[11] = '{1'b0, 48'h0,              1'b0, 1'b1, 3'b111, 10'd0, 1'b0, 10'd0, 1'b0, 48'h0,            11'd0, 1'b0};

    // Reset values
    @(negedge clk);
    chk("rst_wr_ready", 64'(wr_ready), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_oea", 64'(sram_oea), 64'(0));
    chk("rst_webn", 64'(sram_webn), 64'(3'b111));
    chk("rst_sram_a", 64'(sram_a), 64'(0));
    chk("rst_sram_b", 64'(sram_b), 64'(0));
    chk("rst_dib", 64'(sram_dib), 64'(0));
    chk("oeb_tied", 64'(sram_oeb), 64'(0));
    tick();
    rst_n = 1'b1;

    // Table-driven cycle vectors
    for (int i = 0; i < 12; i++) begin
      wr_valid = tbl[i].wv; wr_data = tbl[i].wd; rd_ready = tbl[i].rr; flush = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d_webn", i), 64'(sram_webn), 64'(tbl[i].webn));
      if (tbl[i].webn == 3'b000) chk($sformatf("vec%0d_b", i), 64'(sram_b), 64'(tbl[i].b));
      chk($sformatf("vec%0d_oea", i), 64'(sram_oea), 64'(tbl[i].oea));
      if (tbl[i].oea) chk($sformatf("vec%0d_a", i), 64'(sram_a), 64'(tbl[i].a));
      chk($sformatf("vec%0d_rv", i), 64'(rd_valid), 64'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("vec%0d_rdata", i), 64'(rd_data), 64'(tbl[i].rdat));
      chk($sformatf("vec%0d_level", i), 64'(level), 64'(tbl[i].lvl));
      chk($sformatf("vec%0d_wr_ready", i), 64'(wr_ready), 64'(tbl[i].wrdy));
      tick();
    end
    flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;

    // Fill to capacity with consumer stalled
    acc = 0; n = 0;
    while (n < 1200) begin
      wr_valid = 1'b1; wr_data = pat(acc);
      @(negedge clk);
      if (!wr_ready) break;
      acc++;
      tick();
      n++;
    end
    chk("fill_accepted", 64'(acc), 64'(DEPTH + 2));
    chk("full_level", 64'(level), 64'(1026));
    chk("full_wr_ready", 64'(wr_ready), 64'(0));
    chk("full_first_word", 64'(rd_data), 64'(pat(0)));
    tick();
    // Full with read issue that cycle: write refused now, accepted next cycle
    wr_valid = 1'b1; wr_data = pat(5000); rd_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_wr_ready", 64'(wr_ready), 64'(0));
    tick();
    rd_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_wr_ready", 64'(wr_ready), 64'(1));
    tick();
    @(negedge clk);
    chk("refull_wr_ready", 64'(wr_ready), 64'(0));
    tick();
    drain(1300);

    // Continuous streaming
    for (int k = 0; k < 100; k++) begin
      wr_valid = 1'b1; rd_ready = 1'b1; wr_data = pat(7000 + k);
      @(negedge clk);
      if (k >= 3) begin
        chk("stream_level", 64'(level), 64'(3));
        chk("stream_rd_valid", 64'(rd_valid), 64'(1));
        chk("stream_rd_data", 64'(rd_data), 64'(pat(7000 + k - 3)));
      end
      tick();
    end
    drain(20);

    // Consumer toggling every cycle
    for (int k = 0; k < 200; k++) begin
      wr_valid = 1'b1; rd_ready = k[0]; wr_data = pat(9000 + k);
      tick();
    end
    drain(400);

    // Flush with buffered words and a read in flight
    for (int k = 0; k < 5; k++) begin
      wr_valid = 1'b1; rd_ready = 1'b0; wr_data = pat(11000 + k);
      tick();
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    @(negedge clk);
    chk("preflush_read_issue", 64'(sram_oea), 64'(1));
    tick();
    flush = 1'b1; wr_valid = 1'b1; wr_data = pat(12345);
    @(negedge clk);
    chk("flush_wr_ready", 64'(wr_ready), 64'(0));
    chk("flush_no_write", 64'(sram_webn), 64'(3'b111));
    chk("flush_no_issue", 64'(sram_oea), 64'(0));
    tick();
    flush = 1'b0; wr_valid = 1'b1; wr_data = 48'hABC; rd_ready = 1'b1;
    @(negedge clk);
    chk("postflush_level", 64'(level), 64'(0));
    chk("postflush_rd_valid", 64'(rd_valid), 64'(0));
    chk("postflush_b", 64'(sram_b), 64'(0));
    tick();
    wr_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      chk("postflush_wait_rv", 64'(rd_valid), 64'(0));
      tick();
    end
    @(negedge clk);
    chk("postflush_rv", 64'(rd_valid), 64'(1));
    chk("postflush_data", 64'(rd_data), 64'(48'hABC));
    tick();
    drain(10);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 10; k++) begin
      wr_valid = 1'b1; rd_ready = 1'b1; wr_data = pat(13000 + k);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_ready", 64'(wr_ready), 64'(0));
    chk("arst_rd_valid", 64'(rd_valid), 64'(0));
    chk("arst_rd_data", 64'(rd_data), 64'(0));
    chk("arst_level", 64'(level), 64'(0));
    chk("arst_oea", 64'(sram_oea), 64'(0));
    chk("arst_webn", 64'(sram_webn), 64'(3'b111));
    chk("arst_sram_a", 64'(sram_a), 64'(0));
    chk("arst_sram_b", 64'(sram_b), 64'(0));
    chk("arst_dib", 64'(sram_dib), 64'(0));
    tick();
    rst_n = 1'b1;
    wr_data = pat(14000);
    @(negedge clk);
    chk("rel_wr_ready", 64'(wr_ready), 64'(1));
    chk("rel_rd_valid", 64'(rd_valid), 64'(0));
    chk("rel_b", 64'(sram_b), 64'(0));
    tick();
    wr_valid = 1'b0;
    for (int k = 1; k < 3; k++) tick();
    @(negedge clk);
    chk("rel_first_word", 64'(rd_data), 64'(pat(14000)));
    tick();
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
